midori_share_gen: RTL and testbench
===================================

# midori_share_gen

- Upstream stage of the non-uniform-input Midori64 simulation path.
- Accepts one unshared 64-bit plaintext per transaction and draws two 64-bit masks from an internal xorshift128 PRNG.
- Emits a uniform 3-share sharing on `group_in0/1/2`, which feeds the row-replicating share remapper that drives the masked Midori core.
- Uses valid/ready on both sides, so the testbench can stall either end.

## Interface
Parameters:
- `SEED_X`, 32'd123456789, default PRNG state word x
- `SEED_Y`, 32'd362436069, default PRNG state word y
- `SEED_Z`, 32'd521288629, default PRNG state word z
- `SEED_W`, 32'd88675123, default PRNG state word w

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `pt_in`  in  64  plaintext
- `pt_valid`  in  1  plaintext valid
- `pt_ready`  out  1  block can accept plaintext
- `seed_in`  in  128  PRNG seed, {x,y,z,w} MSB first
- `seed_load`  in  1  seed write strobe
- `group_in0`  out  64  share 0 = r0
- `group_in1`  out  64  share 1 = r1
- `group_in2`  out  64  share 2 = pt ^ r0 ^ r1
- `out_valid`  out  1  shares valid
- `out_ready`  in  1  downstream accepts shares

## Operation
- **FSM states:** IDLE, FILL, OUT.
  - IDLE: `pt_ready`=1. On `pt_valid`, capture `pt_in`, clear word counter, go to FILL.
  - FILL: each cycle the PRNG steps once. The resulting word w goes into `mask[32k+31:32k]`, k = 0..3; `mask[63:0]` = r0, `mask[127:64]` = r1. After k=3, go to OUT.
  - OUT: `out_valid`=1 and shares held stable. On `out_ready`, go to IDLE.
- **PRNG step:**
  - t = x ^ (x<<11)
  - x←y, y←z, z←w
  - w←w ^ (w>>19) ^ t ^ (t>>8)
  - All arithmetic is 32-bit and truncating.
  - The PRNG steps only in FILL.
- **Seed load:**
  - Honoured only in IDLE; ignored in FILL and OUT.
  - An all-zero `seed_in` loads the SEED_* parameters instead, so the state is never zero.
  - Seed load and `pt_valid` in the same IDLE cycle: both take effect, and FILL uses the new seed.
- **Outputs:**
  - `group_in*` are registered and written once on the FILL→OUT transition.
  - Otherwise they hold their last value.

## Timing
- **Reset values:**
  - State IDLE, `pt_ready`=1, `out_valid`=0, all `group_in*`=0, counter 0.
  - PRNG state = SEED_* parameters.
- **Latency:** acceptance edge at cycle 0; FILL occupies cycles 1–4; `out_valid` rises after the edge ending cycle 4, i.e. first visible in cycle 5.
- **Throughput:** minimum 6 cycles per transaction with `out_ready` tied high.
- **Backpressure:** `out_valid` stays high and shares stay stable for as long as `out_ready`=0.
- **Ready timing:** `pt_ready` is a Moore output (state==IDLE) with no combinational path from `out_ready`. It returns high the cycle after the output handshake.
- **Reset mid-operation:** an `rst_n` assertion in any state immediately forces all reset values. Captured plaintext and partial masks are discarded.

## Configuration
- **`SHARE_GEN_EXT_RAND_EN` defined:**
  - Adds port `rand_in` (in, 128), which supplies masks directly.
  - FILL is skipped: IDLE→OUT on acceptance, with `rand_in` sampled in the acceptance cycle.
  - `out_valid` is visible in cycle 1.
  - The PRNG, `seed_in` and `seed_load` are still present but unused.
- **Not defined:** internal PRNG path as described above; no `rand_in` port.

## Structure
- **Package `midori_share_pkg`:**
  - State enum type
  - Default seed constants
  - `FILL_WORDS`=4
  - Mask width constant, 128
- **Sub-module `xorshift128_prng`:**
  - Ports: `clk`, `rst_n`, `step`, `load`, `seed`, `word_out`
  - `word_out` is the current w.
- The top level holds the FSM, plaintext register, mask register and share XOR.

## Test plan
- **Default seed:** reset, pt=0 accepted, `out_ready`=1 → `group_in0[31:0]`=32'hDCA345EA; `group_in2` == `group_in0`^`group_in1`; `out_valid` first high in cycle 5.
- **Recombination:** pt=64'h0123456789ABCDEF → `group_in0`^`group_in1`^`group_in2` == pt, for 1000 random plaintexts.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in OUT → shares constant, `pt_ready`=0, PRNG state unchanged.
- **Zero seed:** `seed_load` with `seed_in`=0 → identical output to the post-reset default-seed run. `seed_load` asserted in FILL → ignored.
- **Reset mid-FILL:** drop `rst_n` at cycle 2 → `out_valid`=0, shares 0, `pt_ready`=1 immediately. The next transaction reproduces the default-seed first output.
- **External randomness:** with `SHARE_GEN_EXT_RAND_EN`, `rand_in`={64'hFFFF…F, 64'h0}, pt=64'h1 → `group_in0`=0, `group_in1`=all-ones, `group_in2`=64'hFFFFFFFFFFFFFFFE, valid in cycle 1.

Source files
------------

// File: rtl/midori_share_pkg.sv
// Shared types and constants for the Midori64 plaintext share generator.
// Holds the FSM state type, default PRNG seed words and the xorshift128 step.
package midori_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_SEED_X = 32'd123456789;
  localparam logic [31:0] DEF_SEED_Y = 32'd362436069;
  localparam logic [31:0] DEF_SEED_Z = 32'd521288629;
  localparam logic [31:0] DEF_SEED_W = 32'd88675123;

  localparam int FILL_WORDS = 4;
  localparam int MASK_W     = 128;

  // State is packed {x,y,z,w}, x in the top word; returns the stepped state.
  function automatic logic [127:0] xorshift_next(input logic [127:0] s);
    logic [31:0] x, y, z, w, t, w_n;
    {x, y, z, w} = s;
    t   = x ^ (x << 11);
    w_n = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {y, z, w, w_n};
  endfunction

endpackage

// File: rtl/xorshift128_prng.sv
// xorshift128 mask generator. While step is high word_out already shows the
// word produced by this cycle's step, so the caller can store it on the same edge.
module xorshift128_prng
  import midori_share_pkg::*;
#(
  parameter logic [31:0] SEED_X = DEF_SEED_X,
  parameter logic [31:0] SEED_Y = DEF_SEED_Y,
  parameter logic [31:0] SEED_Z = DEF_SEED_Z,
  parameter logic [31:0] SEED_W = DEF_SEED_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         load,
  input  logic [127:0] seed,
  output logic [31:0]  word_out
);

  localparam logic [127:0] DEFAULT_STATE = {SEED_X, SEED_Y, SEED_Z, SEED_W};

  logic [127:0] state_q;
  logic [127:0] state_next;

  assign state_next = xorshift_next(state_q);

  // A zero seed would lock the generator at zero, so it selects the defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEFAULT_STATE;
    end else if (load) begin
      state_q <= (seed == '0) ? DEFAULT_STATE : seed;
    end else if (step) begin
      state_q <= state_next;
    end
  end

  assign word_out = step ? state_next[31:0] : state_q[31:0];

endmodule

// File: rtl/midori_share_gen.sv
// Splits one 64-bit plaintext into a uniform 3-share sharing (r0, r1, pt^r0^r1).
// Macro SHARE_GEN_EXT_RAND_EN: masks come from rand_in and the FILL phase is skipped.
module midori_share_gen
  import midori_share_pkg::*;
#(
  parameter logic [31:0] SEED_X = DEF_SEED_X,
  parameter logic [31:0] SEED_Y = DEF_SEED_Y,
  parameter logic [31:0] SEED_Z = DEF_SEED_Z,
  parameter logic [31:0] SEED_W = DEF_SEED_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   pt_in,
  input  logic          pt_valid,
  output logic          pt_ready,
  input  logic [127:0]  seed_in,
  input  logic          seed_load,
`ifdef SHARE_GEN_EXT_RAND_EN
  input  logic [127:0]  rand_in,
`endif
  output logic [63:0]   group_in0,
  output logic [63:0]   group_in1,
  output logic [63:0]   group_in2,
  output logic          out_valid,
  input  logic          out_ready
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds with its data stable until then, ready is Moore.

  state_t              state;
  logic [1:0]          cnt;
  logic [63:0]         pt_q;
  logic [MASK_W-1:0]   mask;
  logic [MASK_W-1:0]   mask_next;
  logic [31:0]         prng_word;
  logic                prng_step;
  logic                prng_load;

`ifdef SHARE_GEN_EXT_RAND_EN
  assign prng_step = 1'b0;
`else
  assign prng_step = (state == ST_FILL);
`endif
  assign prng_load = seed_load && (state == ST_IDLE);

  xorshift128_prng #(
    .SEED_X (SEED_X),
    .SEED_Y (SEED_Y),
    .SEED_Z (SEED_Z),
    .SEED_W (SEED_W)
  ) u_prng (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (prng_step),
    .load     (prng_load),
    .seed     (seed_in),
    .word_out (prng_word)
  );

  // Mask with this cycle's word merged in, so the last word reaches the shares directly.
  always_comb begin
    mask_next = mask;
    mask_next[{cnt, 5'd0} +: 32] = prng_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pt_q      <= '0;
      mask      <= '0;
      pt_ready  <= 1'b1;
      out_valid <= 1'b0;
      group_in0 <= '0;
      group_in1 <= '0;
      group_in2 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pt_valid) begin
            pt_q     <= pt_in;
            cnt      <= '0;
            pt_ready <= 1'b0;
`ifdef SHARE_GEN_EXT_RAND_EN
            mask      <= rand_in;
            group_in0 <= rand_in[63:0];
            group_in1 <= rand_in[127:64];
            group_in2 <= pt_in ^ rand_in[63:0] ^ rand_in[127:64];
            out_valid <= 1'b1;
            state     <= ST_OUT;
`else
            state    <= ST_FILL;
`endif
          end
        end
        ST_FILL: begin
          mask <= mask_next;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'(FILL_WORDS - 1)) begin
            group_in0 <= mask_next[63:0];
            group_in1 <= mask_next[127:64];
            group_in2 <= pt_q ^ mask_next[63:0] ^ mask_next[127:64];
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pt_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          pt_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midori_share_gen.sv
// Bench for midori_share_gen: randomized transactions checked against a
// reference model of the xorshift128 generator and the share equations.
module tb_midori_share_gen;

  logic          clk;
  logic          rst_n;
  logic [63:0]   pt_in;
  logic          pt_valid;
  logic          pt_ready;
  logic [127:0]  seed_in;
  logic          seed_load;
  logic [127:0]  rand_in;
  logic [63:0]   group_in0, group_in1, group_in2;
  logic          out_valid;
  logic          out_ready;

  int n_vec = 0;
  int n_err = 0;

`ifdef SHARE_GEN_EXT_RAND_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 5;
`endif

  midori_share_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pt_in     (pt_in),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .seed_in   (seed_in),
    .seed_load (seed_load),
`ifdef SHARE_GEN_EXT_RAND_EN
    .rand_in   (rand_in),
`endif
    .group_in0 (group_in0),
    .group_in1 (group_in1),
    .group_in2 (group_in2),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mx, my, mz, mw;

  function automatic void model_seed(input logic [127:0] s);
    if (s == '0) begin
      mx = 32'd123456789; my = 32'd362436069; mz = 32'd521288629; mw = 32'd88675123;
    end else begin
      {mx, my, mz, mw} = s;
    end
  endfunction

  function automatic logic [31:0] model_rand();
    logic [31:0] t;
    t  = mx ^ (mx << 11);
    mx = my;
    my = mz;
    mz = mw;
    mw = mw ^ (mw >> 19) ^ t ^ (t >> 8);
    return mw;
  endfunction

  function automatic void model_txn(input logic [63:0] pt, input logic [127:0] rnd,
                                    output logic [63:0] e0, output logic [63:0] e1,
                                    output logic [63:0] e2);
    logic [127:0] r;
`ifdef SHARE_GEN_EXT_RAND_EN
    r = rnd;
`else
    r = rnd;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = model_rand();
`endif
    e0 = r[63:0];
    e1 = r[127:64];
    e2 = pt ^ e0 ^ e1;
  endfunction

  // ---------------- driver ----------------
  // Entered and left on a falling edge. Returns the captured shares, the cycle
  // in which out_valid was first seen, and whether the handshake rules held.
  task automatic drive_txn(input logic [63:0] pt, input logic [127:0] rnd, input int stall,
                           input bit ld_with_pt, input logic [127:0] ld_seed, input bit ld_in_fill,
                           output logic [63:0] g0, output logic [63:0] g1, output logic [63:0] g2,
                           output int lat, output bit proto_ok);
    int guard;
    guard = 0;
    while (!pt_ready && guard < 100) begin @(negedge clk); guard++; end
    pt_in     = pt;
    pt_valid  = 1'b1;
    rand_in   = rnd;
    out_ready = (stall == 0);
    seed_load = ld_with_pt;
    seed_in   = ld_seed;
    @(negedge clk);
    pt_valid  = 1'b0;
    seed_load = 1'b0;
    pt_in     = {$urandom, $urandom};
    rand_in   = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 50) begin
      if (ld_in_fill && lat == 2) begin
        seed_load = 1'b1;
        seed_in   = ld_seed;
      end else begin
        seed_load = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    seed_load = 1'b0;
    g0 = group_in0; g1 = group_in1; g2 = group_in2;
    proto_ok = out_valid && !pt_ready;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (group_in0 !== g0 || group_in1 !== g1 || group_in2 !== g2 || !out_valid || pt_ready)
        proto_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (pt_ready !== 1'b1 || out_valid !== 1'b0) proto_ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL reset_pt_ready: got %b want 1", pt_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (group_in0 !== 64'd0) begin n_err++; $display("FAIL reset_g0: got %h want 0", group_in0); end
    n_vec++; if ({group_in1, group_in2} !== 128'd0) begin n_err++; $display("FAIL reset_g12: got %h %h want 0", group_in1, group_in2); end
    model_seed('0);
  endtask

  task automatic test_default_seed();
    logic [63:0] g0, g1, g2, e0, e1, e2;
    int lat; bit ok;
    drive_txn(64'd0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, 0, g0, g1, g2, lat, ok);
    model_txn(64'd0, rand_in, e0, e1, e2);
`ifndef SHARE_GEN_EXT_RAND_EN
    n_vec++; if (g0[31:0] !== 32'hDCA345EA) begin n_err++; $display("FAIL default_first_word: got %h want dca345ea", g0[31:0]); end
`endif
    n_vec++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL default_latency: got %0d want %0d", lat, EXP_LAT); end
    n_vec++; if (g2 !== (g0 ^ g1)) begin n_err++; $display("FAIL default_g2: got %h want %h", g2, g0 ^ g1); end
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL default_shares: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL default_handshake: got %b want 1", ok); end
  endtask

  task automatic test_recombination();
    logic [63:0] pt, g0, g1, g2, e0, e1, e2;
    logic [127:0] rnd;
    int lat; bit ok;
    for (int n = 0; n < 1001; n++) begin
      pt  = (n == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive_txn(pt, rnd, $urandom_range(0, 3), 0, '0, 0, g0, g1, g2, lat, ok);
      model_txn(pt, rnd, e0, e1, e2);
      n_vec++; if ((g0 ^ g1 ^ g2) !== pt) begin n_err++; $display("FAIL recombine[%0d]: got %h want %h", n, g0 ^ g1 ^ g2, pt); end
      n_vec++; if ({g0, g1} !== {e0, e1}) begin n_err++; $display("FAIL masks[%0d]: got %h %h want %h %h", n, g0, g1, e0, e1); end
      n_vec++; if (ok !== 1'b1 || lat !== EXP_LAT) begin n_err++; $display("FAIL protocol[%0d]: got ok=%b lat=%0d want ok=1 lat=%0d", n, ok, lat, EXP_LAT); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pt, g0, g1, g2, e0, e1, e2;
    logic [127:0] rnd;
    int lat; bit ok;
    pt = {$urandom, $urandom}; rnd = {$urandom, $urandom, $urandom, $urandom};
    drive_txn(pt, rnd, 10, 0, '0, 0, g0, g1, g2, lat, ok);
    model_txn(pt, rnd, e0, e1, e2);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_hold: got %b want 1", ok); end
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL stall_shares: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
    pt = {$urandom, $urandom}; rnd = {$urandom, $urandom, $urandom, $urandom};
    drive_txn(pt, rnd, 0, 0, '0, 0, g0, g1, g2, lat, ok);
    model_txn(pt, rnd, e0, e1, e2);
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL after_stall: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
  endtask

  task automatic test_seed_load();
    logic [63:0] pt, g0, g1, g2, e0, e1, e2;
    logic [127:0] s;
    int lat; bit ok;
    seed_in = '0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
`ifndef SHARE_GEN_EXT_RAND_EN
    model_seed('0);
`endif
    s  = {$urandom | 32'd1, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom};
    drive_txn(pt, '0, 0, 0, s, 1, g0, g1, g2, lat, ok);
    model_txn(pt, '0, e0, e1, e2);
`ifndef SHARE_GEN_EXT_RAND_EN
    n_vec++; if (g0[31:0] !== 32'hDCA345EA) begin n_err++; $display("FAIL zero_seed_word: got %h want dca345ea", g0[31:0]); end
`endif
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL zero_seed_shares: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
    s  = {$urandom, $urandom | 32'd1, $urandom, $urandom};
    pt = {$urandom, $urandom};
    drive_txn(pt, '0, 1, 1, s, 0, g0, g1, g2, lat, ok);
`ifndef SHARE_GEN_EXT_RAND_EN
    model_seed(s);
`endif
    model_txn(pt, '0, e0, e1, e2);
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL seed_with_pt: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
  endtask

  task automatic test_reset_mid_fill();
    logic [63:0] pt, g0, g1, g2, e0, e1, e2;
    int lat; bit ok;
    pt_in = {$urandom, $urandom}; pt_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    pt_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL midrst_pt_ready: got %b want 1", pt_ready); end
    n_vec++; if ({group_in0, group_in1, group_in2} !== 192'd0) begin n_err++; $display("FAIL midrst_shares: got %h %h %h want 0", group_in0, group_in1, group_in2); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_seed('0);
    pt = {$urandom, $urandom};
    drive_txn(pt, {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, 0, g0, g1, g2, lat, ok);
    model_txn(pt, rand_in, e0, e1, e2);
`ifndef SHARE_GEN_EXT_RAND_EN
    n_vec++; if (g0[31:0] !== 32'hDCA345EA) begin n_err++; $display("FAIL midrst_replay: got %h want dca345ea", g0[31:0]); end
`endif
    n_vec++; if ({g0, g1, g2} !== {e0, e1, e2}) begin n_err++; $display("FAIL midrst_shares2: got %h %h %h want %h %h %h", g0, g1, g2, e0, e1, e2); end
  endtask

`ifdef SHARE_GEN_EXT_RAND_EN
  task automatic test_ext_rand();
    logic [63:0] g0, g1, g2;
    int lat; bit ok;
    drive_txn(64'h1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 2, 0, '0, 0, g0, g1, g2, lat, ok);
    n_vec++; if (g0 !== 64'h0) begin n_err++; $display("FAIL ext_g0: got %h want 0", g0); end
    n_vec++; if (g1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL ext_g1: got %h want ffffffffffffffff", g1); end
    n_vec++; if (g2 !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL ext_g2: got %h want fffffffffffffffe", g2); end
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL ext_latency: got %0d want 1", lat); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    pt_in = '0; pt_valid = 1'b0; seed_in = '0; seed_load = 1'b0;
    rand_in = '0; out_ready = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_default_seed();
    test_recombination();
    test_backpressure();
    test_seed_load();
    test_reset_mid_fill();
`ifdef SHARE_GEN_EXT_RAND_EN
    test_ext_rand();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
